// File: rtl/seatbelt_reminder_ctrl.sv
// seatbelt_reminder_ctrl: sequences dash lamp and chime from the seatbelt-light request and ignition.
module seatbelt_reminder_ctrl #(
   parameter int BULB_TICKS  = 3,
   parameter int GRACE_TICKS = 4,
   parameter int CHIME_TICKS = 6,
   parameter int FLASH_HALF  = 2
) (
   input  logic clk,
   input  logic reset_n,
   input  logic sbl,
   input  logic ign_on,
   input  logic tick,
   output logic lamp,
   output logic chime,
   output logic warn_act
);
   localparam int M1   = BULB_TICKS > GRACE_TICKS ? BULB_TICKS : GRACE_TICKS;
   localparam int M2   = CHIME_TICKS > FLASH_HALF ? CHIME_TICKS : FLASH_HALF;
   localparam int MAXP = M1 > M2 ? M1 : M2;
   localparam int CW   = $clog2(MAXP) + 1;
   typedef enum logic [2:0] {OFF, CHECK, IDLE, GRACE, WARN, SILENT} state_t;
   state_t state, nxt;
   logic [CW-1:0] cnt, cnt_d, pcnt, pcnt_d;
   logic phase, phase_d, tmo_bulb, tmo_grace, tmo_chime, in_warn, flip, lamp_d;
   assign tmo_bulb  = tick && cnt == CW'(BULB_TICKS - 1);
   assign tmo_grace = tick && cnt == CW'(GRACE_TICKS - 1);
   assign tmo_chime = tick && cnt == CW'(CHIME_TICKS - 1);
   always_comb begin
      nxt = OFF;
      if (ign_on)
         case (state)
            OFF:     nxt = CHECK;
            CHECK:   nxt = tmo_bulb ? (sbl ? GRACE : IDLE) : CHECK;
            IDLE:    nxt = sbl ? GRACE : IDLE;
            GRACE:   nxt = !sbl ? IDLE : tmo_grace ? WARN : GRACE;
            WARN:    nxt = !sbl ? IDLE : tmo_chime ? SILENT : WARN;
            SILENT:  nxt = sbl ? SILENT : IDLE;
            default: nxt = OFF;
         endcase
   end
   // flash phase runs only while WARN persists, so every WARN entry starts with the lamp lit
   always_comb begin
      cnt_d   = (nxt != state) ? '0 : tick ? cnt + CW'(1) : cnt;
      in_warn = nxt == WARN && state == WARN;
      flip    = in_warn && tick && pcnt == CW'(FLASH_HALF - 1);
      pcnt_d  = (!in_warn || flip) ? '0 : tick ? pcnt + CW'(1) : pcnt;
      phase_d = in_warn && (phase ^ flip);
      lamp_d  = (nxt inside {CHECK, GRACE, SILENT}) || (nxt == WARN && !phase_d);
   end
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state    <= OFF;
         cnt      <= '0;
         pcnt     <= '0;
         phase    <= 1'b0;
         lamp     <= 1'b0;
         chime    <= 1'b0;
         warn_act <= 1'b0;
      end else begin
         state    <= nxt;
         cnt      <= cnt_d;
         pcnt     <= pcnt_d;
         phase    <= phase_d;
         lamp     <= lamp_d;
         chime    <= nxt == WARN;
         warn_act <= nxt == WARN;
      end
   end
endmodule

// File: tb/tb_seatbelt_reminder_ctrl.sv
// tb_seatbelt_reminder_ctrl: vector table plus directed corner sequences for the seatbelt reminder.
module tb_seatbelt_reminder_ctrl;
   logic clk = 1'b0, reset_n = 1'b0, sbl = 1'b0, ign_on = 1'b0, tick = 1'b0;
   logic lamp, chime, warn_act;
   int tests = 0, fails = 0;
   typedef struct {logic rn, ign, s, t, l, c, w;} vec_t;
   vec_t v[$];

   seatbelt_reminder_ctrl dut (
      .clk(clk), .reset_n(reset_n), .sbl(sbl), .ign_on(ign_on), .tick(tick),
      .lamp(lamp), .chime(chime), .warn_act(warn_act)
   );

   always #5 clk = ~clk;

   task automatic add(input logic rn, ign, s, t, l, c, w);
      vec_t x;
      x = '{rn, ign, s, t, l, c, w};
      v.push_back(x);
   endtask

   task automatic step(input logic rn, ign, s, t);
      @(negedge clk);
      reset_n = rn; ign_on = ign; sbl = s; tick = t;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic l, c, w);
      tests++;
      if ({lamp, chime, warn_act} !== {l, c, w}) begin
         fails++;
         $display("FAIL %s: lamp/chime/warn_act got %b%b%b expected %b%b%b",
                  name, lamp, chime, warn_act, l, c, w);
      end
   endtask

   initial begin
      // key-on unbuckled: 3-clock bulb check then idle
      add(0,0,0,1, 0,0,0);
      add(1,1,0,1, 1,0,0); add(1,1,0,1, 1,0,0); add(1,1,0,1, 1,0,0);
      add(1,1,0,1, 0,0,0); add(1,1,0,1, 0,0,0);
      // key-off, key-on buckled-request: sbl dip during CHECK is ignored
      add(1,0,0,1, 0,0,0);
      add(1,1,1,1, 1,0,0); add(1,1,0,1, 1,0,0); add(1,1,1,1, 1,0,0);
      add(1,1,1,1, 1,0,0); add(1,1,1,1, 1,0,0); add(1,1,1,1, 1,0,0); add(1,1,1,1, 1,0,0);
      // WARN flash pattern 1,1,0,0,1,1 with chime
      add(1,1,1,1, 1,1,1); add(1,1,1,1, 1,1,1); add(1,1,1,1, 0,1,1);
      add(1,1,1,1, 0,1,1); add(1,1,1,1, 1,1,1); add(1,1,1,1, 1,1,1);
      // SILENT steady lamp, then unbuckle -> IDLE
      add(1,1,1,1, 1,0,0); add(1,1,1,1, 1,0,0); add(1,1,0,1, 0,0,0);
      // re-arm: GRACE 4 clocks, WARN restarts full sequence
      add(1,1,1,1, 1,0,0); add(1,1,1,1, 1,0,0); add(1,1,1,1, 1,0,0); add(1,1,1,1, 1,0,0);
      add(1,1,1,1, 1,1,1); add(1,1,1,1, 1,1,1); add(1,1,1,1, 0,1,1);
      // drop sbl at WARN cnt=2, then GRACE restarts its 4-tick count
      add(1,1,0,1, 0,0,0);
      add(1,1,1,1, 1,0,0); add(1,1,1,1, 1,0,0); add(1,1,1,1, 1,0,0); add(1,1,1,1, 1,0,0);
      add(1,1,1,1, 1,1,1);
      for (int i = 0; i < v.size(); i++) begin
         step(v[i].rn, v[i].ign, v[i].s, v[i].t);
         chk($sformatf("vec%0d", i), v[i].l, v[i].c, v[i].w);
      end

      // tick every 4th clock in GRACE: WARN 16 clocks after GRACE entry
      step(0,0,0,1);
      for (int i = 0; i < 4; i++) step(1,1,1,1);
      chk("slow_grace_entry", 1,0,0);
      for (int k = 1; k <= 16; k++) begin
         step(1,1,1, (k % 4) == 0);
         chk($sformatf("slow_grace_k%0d", k), 1'b1, k == 16, k == 16);
      end
      for (int i = 0; i < 20; i++) begin
         step(1,1,1,0);
         chk($sformatf("freeze%0d", i), 1,1,1);
      end
      step(1,1,1,1); chk("unfreeze_t1", 1,1,1);
      step(1,1,1,1); chk("unfreeze_t2", 0,1,1);

      // ignition off on the same edge as the chime timeout
      step(0,0,0,1);
      for (int i = 0; i < 8; i++) step(1,1,1,1);
      chk("warn_entry", 1,1,1);
      for (int i = 0; i < 5; i++) step(1,1,1,1);
      chk("warn_cnt5", 1,1,1);
      step(1,0,1,1); chk("ign_off_at_timeout", 0,0,0);
      step(1,0,1,1); chk("ign_off_hold", 0,0,0);

      // sbl falls on the GRACE timeout edge: IDLE wins over WARN
      step(0,0,0,1);
      for (int i = 0; i < 7; i++) step(1,1,1,1);
      chk("grace_cnt3", 1,0,0);
      step(1,1,0,1); chk("sbl_beats_timeout", 0,0,0);

      // reset mid-GRACE, then full bulb check repeats
      step(0,0,0,1);
      for (int i = 0; i < 5; i++) step(1,1,1,1);
      chk("mid_grace", 1,0,0);
      step(0,1,1,1); chk("reset_mid_grace", 0,0,0);
      step(1,1,0,1); chk("recheck1", 1,0,0);
      step(1,1,0,1); chk("recheck2", 1,0,0);
      step(1,1,0,1); chk("recheck3", 1,0,0);
      step(1,1,0,1); chk("recheck_idle", 0,0,0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
